// File: rtl/exe_issue_controller.sv
// exe_issue_controller: instruction queue feeding a single ALU, with branch flush,
// write-back sequencing and a sticky ALU-timeout flag.
module exe_issue_controller #(
   parameter int WIDTH      = 32,
   parameter int CHANNELS   = 3,
   parameter int ADDR_WIDTH = 16,
   parameter int OP_WIDTH   = 6,
   parameter int DEPTH      = 4,
   parameter int TIMEOUT    = 255,
   parameter int NOP_OP     = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          iDecodeValid,
   output logic                          oDecodeReady,
   input  logic [OP_WIDTH-1:0]           iOperation,
   input  logic [WIDTH*CHANNELS-1:0]     iSource0,
   input  logic [WIDTH*CHANNELS-1:0]     iSource1,
   input  logic [ADDR_WIDTH-1:0]         iDestination,
   output logic [OP_WIDTH-1:0]           oALUOperation,
   output logic [WIDTH*CHANNELS-1:0]     oALUSource0,
   output logic [WIDTH*CHANNELS-1:0]     oALUSource1,
   output logic                          oTriggerALU,
   input  logic                          iALUOutputReady,
   input  logic [WIDTH*CHANNELS-1:0]     iALUResult,
   input  logic                          iBranchTaken,
   input  logic                          iBranchNotTaken,
   output logic                          oRAMWriteEnable,
   output logic [ADDR_WIDTH-1:0]         oRAMWriteAddress,
   output logic [WIDTH*CHANNELS-1:0]     oRAMWriteData,
   output logic                          oJumpFlag,
   output logic [ADDR_WIDTH-1:0]         oJumpIp,
   output logic                          oBusy,
   output logic [ADDR_WIDTH-1:0]         oLastDestination,
   output logic [$clog2(DEPTH):0]        oQueueCount,
   output logic                          oTimeout
);
   localparam int RW = WIDTH * CHANNELS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
   localparam logic [OP_WIDTH-1:0] NOP = OP_WIDTH'(NOP_OP);

   typedef enum logic [1:0] {IDLE, WAIT_ALU, WRITEBACK} state_t;

   logic [OP_WIDTH-1:0]   op_mem  [DEPTH];
   logic [RW-1:0]         s0_mem  [DEPTH];
   logic [RW-1:0]         s1_mem  [DEPTH];
   logic [ADDR_WIDTH-1:0] dst_mem [DEPTH];

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic                  ready_q;
   logic [WW-1:0]         wait_q, wait_d, wait_inc;
   logic                  tmo_q, tmo_d;
   logic                  trig_q, jump_q;
   logic [ADDR_WIDTH-1:0] jip_q, waddr_q, ex_dst_q;
   logic [RW-1:0]         wdata_q, ex_s0_q, ex_s1_q;
   logic [OP_WIDTH-1:0]   ex_op_q;
   logic                  push, pop, flush;

   assign push     = iDecodeValid & ready_q;
   assign wait_inc = wait_q + WW'(1);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: if (cnt_q != '0) begin
            pop     = 1'b1;
            wait_d  = '0;
            state_d = WAIT_ALU;
         end
         WAIT_ALU: if (iALUOutputReady) begin
            flush   = iBranchTaken;
            state_d = (!iBranchTaken && !iBranchNotTaken && ex_op_q != NOP) ? WRITEBACK : IDLE;
         end else if (wait_inc == TMO) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
         end else begin
            wait_d  = wait_inc;
         end
         default: state_d = IDLE;
      endcase
   end

   // A taken branch empties the queue and drops any push arriving in the same cycle.
   assign cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
   assign wr_d  = flush ? '0 : wr_q + AW'(push);
   assign rd_d  = flush ? '0 : rd_q + AW'(pop);

   always_ff @(posedge clk)
      if (push && !flush) begin
         op_mem[wr_q]  <= iOperation;
         s0_mem[wr_q]  <= iSource0;
         s1_mem[wr_q]  <= iSource1;
         dst_mem[wr_q] <= iDestination;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         ready_q  <= 1'b0;
         wait_q   <= '0;
         tmo_q    <= 1'b0;
         trig_q   <= 1'b0;
         jump_q   <= 1'b0;
         jip_q    <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         ex_op_q  <= '0;
         ex_s0_q  <= '0;
         ex_s1_q  <= '0;
         ex_dst_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ready_q <= cnt_d < CW'(DEPTH);
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         trig_q  <= pop;
         jump_q  <= flush;
         if (flush) jip_q <= ex_dst_q;
         if (state_d == WRITEBACK) begin
            waddr_q <= ex_dst_q;
            wdata_q <= iALUResult;
         end
         if (pop) begin
            ex_op_q  <= op_mem[rd_q];
            ex_s0_q  <= s0_mem[rd_q];
            ex_s1_q  <= s1_mem[rd_q];
            ex_dst_q <= dst_mem[rd_q];
         end
      end

   assign oDecodeReady     = ready_q;
   assign oALUOperation    = ex_op_q;
   assign oALUSource0      = ex_s0_q;
   assign oALUSource1      = ex_s1_q;
   assign oLastDestination = ex_dst_q;
   assign oTriggerALU      = trig_q;
   assign oRAMWriteEnable  = state_q == WRITEBACK;
   assign oRAMWriteAddress = waddr_q;
   assign oRAMWriteData    = wdata_q;
   assign oJumpFlag        = jump_q;
   assign oJumpIp          = jip_q;
   assign oBusy            = (state_q != IDLE) | (cnt_q != '0);
   assign oQueueCount      = cnt_q;
   assign oTimeout         = tmo_q;
endmodule

// File: tb/tb_exe_issue_controller.sv
// tb_exe_issue_controller: directed and random stimulus checked against a
// transaction-level model of the issue queue and ALU handshake.
module tb_exe_issue_controller;
   localparam int RW = 96;
   localparam int DEPTH = 4;
   localparam int TMO = 8;

   typedef struct packed {
      logic [5:0]    op;
      logic [RW-1:0] s0;
      logic [RW-1:0] s1;
      logic [15:0]   dst;
   } ins_t;

   logic clk = 1'b0, rst_n = 1'b1;
   logic dec_v = 1'b0, alu_rdy = 1'b0, bt = 1'b0, bnt = 1'b0;
   logic [5:0] op = '0;
   logic [RW-1:0] s0 = '0, s1 = '0, res = '0;
   logic [15:0] dst = '0;

   logic dec_rdy, trig, wen, jump, busy, tmo;
   logic [5:0] alu_op;
   logic [RW-1:0] alu_s0, alu_s1, wdata;
   logic [15:0] waddr, jip, last_dst;
   logic [2:0] qcnt;

   exe_issue_controller #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .iDecodeValid(dec_v), .oDecodeReady(dec_rdy),
      .iOperation(op), .iSource0(s0), .iSource1(s1), .iDestination(dst),
      .oALUOperation(alu_op), .oALUSource0(alu_s0), .oALUSource1(alu_s1), .oTriggerALU(trig),
      .iALUOutputReady(alu_rdy), .iALUResult(res), .iBranchTaken(bt), .iBranchNotTaken(bnt),
      .oRAMWriteEnable(wen), .oRAMWriteAddress(waddr), .oRAMWriteData(wdata),
      .oJumpFlag(jump), .oJumpIp(jip), .oBusy(busy), .oLastDestination(last_dst),
      .oQueueCount(qcnt), .oTimeout(tmo)
   );

   always #5 clk = ~clk;

   int tests = 0, failed = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: queue of pending instructions, one in-flight instruction, a pending write.
   ins_t q[$];
   ins_t ex;
   bit m_fly, m_wb, e_trig, e_jump, e_tmo, e_rdy;
   int m_wait;
   logic [15:0] e_jip, e_waddr;
   logic [RW-1:0] e_wdata;

   task automatic m_reset();
      q.delete();
      ex = '0;
      m_fly = 0; m_wb = 0; e_trig = 0; e_jump = 0; e_tmo = 0; e_rdy = 0;
      m_wait = 0; e_jip = '0; e_waddr = '0; e_wdata = '0;
   endtask

   task automatic m_step();
      bit fl = 0;
      bit acc = dec_v && e_rdy;
      e_trig = 0;
      e_jump = 0;
      if (m_wb) m_wb = 0;
      else if (m_fly) begin
         if (alu_rdy) begin
            m_fly = 0;
            if (bt) begin e_jump = 1; e_jip = ex.dst; fl = 1; end
            else if (!bnt && ex.op != 0) begin m_wb = 1; e_waddr = ex.dst; e_wdata = res; end
         end else if (++m_wait == TMO) begin
            m_fly = 0;
            e_tmo = 1;
         end
      end else if (q.size() > 0) begin
         ex = q.pop_front();
         m_fly = 1; m_wait = 0; e_trig = 1;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(ins_t'{op, s0, s1, dst});
      e_rdy = q.size() < DEPTH;
   endtask

   task automatic compare();
      check("ready", dec_rdy, e_rdy);
      check("count", qcnt, q.size());
      check("busy", busy, m_fly || m_wb || q.size() != 0);
      check("trigger", trig, e_trig);
      check("jump", jump, e_jump);
      check("wen", wen, m_wb);
      check("timeout", tmo, e_tmo);
      check("alu_op", alu_op, ex.op);
      check("alu_src0", alu_s0, ex.s0);
      check("alu_src1", alu_s1, ex.s1);
      check("last_dst", last_dst, ex.dst);
      if (e_jump) check("jump_ip", jip, e_jip);
      if (m_wb) begin
         check("waddr", waddr, e_waddr);
         check("wdata", wdata, e_wdata);
      end
   endtask

   task automatic cyc(input logic v, input logic [5:0] o, input logic [15:0] d,
                      input logic r, input logic t, input logic n, input logic [RW-1:0] rs);
      @(negedge clk);
      compare();
      dec_v = v; op = o; dst = d; alu_rdy = r; bt = t; bnt = n; res = rs;
      s0 = {$urandom, $urandom, $urandom};
      s1 = {$urandom, $urandom, $urandom};
      m_step();
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_ready", dec_rdy, 1'b0);
      check("rst_count", qcnt, 0);
      check("rst_busy", busy, 1'b0);
      check("rst_trig", trig, 1'b0);
      check("rst_wen", wen, 1'b0);
      check("rst_jump", jump, 1'b0);
      check("rst_tmo", tmo, 1'b0);
      check("rst_outs", {alu_op, last_dst, jip, waddr}, '0);
      check("rst_data", {alu_s0 | alu_s1 | wdata}, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      dec_v = 0; alu_rdy = 0; bt = 0; bnt = 0;
      rst_n = 1'b1;
      m_reset();
      m_step();
      @(posedge clk);
   endtask

   initial begin
      do_reset();
      // Single ADD with ALU returning after three cycles.
      cyc(1, 6'd1, 16'h0010, 0, 0, 0, '0);
      repeat (4) cyc(0, 0, 0, 0, 0, 0, '0);
      cyc(0, 0, 0, 1, 0, 0, {32'd1, 32'd2, 32'd3});
      repeat (2) cyc(0, 0, 0, 0, 0, 0, '0);
      // Five back-to-back pushes against a stalled ALU.
      for (int i = 0; i < 5; i++) cyc(1, 6'd2, 16'(i), 0, 0, 0, '0);
      repeat (3) cyc(1, 6'd2, 16'h0099, 0, 0, 0, '0);
      // Taken branch flushes the queue.
      cyc(0, 0, 0, 1, 1, 0, '0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) cyc(1, 6'd3, 16'h0040, 0, 0, 0, '0);
      cyc(0, 0, 0, 1, 1, 1, '0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, '0);
      // NOP with not-taken branch, then a normal head.
      cyc(1, 6'd0, 16'h0077, 0, 0, 0, '0);
      cyc(1, 6'd5, 16'h0078, 0, 0, 0, '0);
      cyc(0, 0, 0, 1, 0, 1, '0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, '0);
      // ALU never ready: timeout then next instruction issues.
      repeat (TMO + 4) cyc(0, 0, 0, 0, 0, 0, '0);
      // Reset during WAIT_ALU with instructions queued.
      for (int i = 0; i < 3; i++) cyc(1, 6'd1, 16'h0100, 0, 0, 0, '0);
      do_reset();
      repeat (3) cyc(0, 0, 0, 1, 0, 0, {3{32'hdead}});
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cyc($urandom_range(0, 9) < 6, 6'($urandom_range(0, 3)), 16'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
             {$urandom, $urandom, $urandom});
      end
      cyc(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      compare();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/exe_issue_controller.md
EXE_ISSUE_CONTROLLER -- requirements
Module: exe_issue_controller

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, meaning bits per data channel.
- REQ-002 SHALL have parameter CHANNELS, default 3, meaning channels per data row; row width RW = WIDTH*CHANNELS.
- REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning destination/RAM address width.
- REQ-004 SHALL have parameter OP_WIDTH, default 6, meaning opcode width.
- REQ-005 SHALL have parameter DEPTH, default 4, meaning instruction queue entries; power of two, >=2.
- REQ-006 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles spent waiting on the ALU.
- REQ-007 SHALL have parameter NOP_OP, default 0, meaning opcode that suppresses write-back.
- REQ-008 Clock  in  1  single clock; all state on rising edge.
- REQ-009 Reset  in  1  asynchronous, active-low reset.
- REQ-010 iDecodeValid  in  1  decoded instruction present; oDecodeReady  out  1  queue can accept.
- REQ-011 iOperation  in  OP_WIDTH; iSource0, iSource1  in  RW; iDestination  in  ADDR_WIDTH.
- REQ-012 oALUOperation  out  OP_WIDTH; oALUSource0, oALUSource1  out  RW; oTriggerALU  out  1  start pulse.
- REQ-013 iALUOutputReady  in  1; iALUResult  in  RW; iBranchTaken, iBranchNotTaken  in  1, qualified by iALUOutputReady.
- REQ-014 oRAMWriteEnable  out  1; oRAMWriteAddress  out  ADDR_WIDTH; oRAMWriteData  out  RW.
- REQ-015 oJumpFlag  out  1; oJumpIp  out  ADDR_WIDTH; oBusy  out  1; oLastDestination  out  ADDR_WIDTH.
- REQ-016 oQueueCount  out  log2(DEPTH)+1; oTimeout  out  1  sticky ALU-timeout flag.

Function
- REQ-017 Push SHALL occur at an edge where iDecodeValid & oDecodeReady; entry {op, src0, src1, dest} stored at the write pointer.
- REQ-018 oDecodeReady SHALL equal (oQueueCount < DEPTH), driven from registers only; no full bypass, even if a pop occurs in the same cycle.
- REQ-019 Pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
- REQ-020 FSM states SHALL be IDLE, WAIT_ALU, WRITEBACK.
- REQ-021 IDLE with count>0 SHALL pop the head into execute registers (op, sources, dest), pulse oTriggerALU high for exactly one cycle, and go to WAIT_ALU.
- REQ-022 Latency: instruction pushed into an empty queue at edge E SHALL see oTriggerALU high in the cycle after edge E+1.
- REQ-023 oALUOperation, oALUSource0/1, and oLastDestination SHALL hold the execute registers, stable until the next issue.
- REQ-024 In WAIT_ALU on iALUOutputReady with iBranchTaken: at the next edge, oJumpFlag SHALL be high for one cycle with oJumpIp = execute dest, the queue SHALL flush (count=0; a same-cycle push is dropped), no write-back, next state IDLE.
- REQ-025 In WAIT_ALU on iALUOutputReady with iBranchNotTaken: no write, no flush, next state IDLE.
- REQ-026 On iALUOutputReady, no branch, op != NOP_OP: capture iALUResult and dest, go to WRITEBACK; in WRITEBACK, oRAMWriteEnable SHALL be high for exactly one cycle, then IDLE.
- REQ-027 On iALUOutputReady, no branch, op == NOP_OP: no write, next state IDLE.
- REQ-028 If iBranchTaken and iBranchNotTaken are both high, iBranchTaken SHALL win.
- REQ-029 Wait counter SHALL clear on issue and increment each WAIT_ALU cycle without iALUOutputReady.
- REQ-030 At count == TIMEOUT, the FSM SHALL set oTimeout (sticky), drop the instruction without write, and go to IDLE.
- REQ-031 oBusy SHALL equal (state != IDLE) | (count != 0).
- REQ-032 iALUOutputReady outside WAIT_ALU SHALL be ignored.

Reset
- REQ-033 Reset low SHALL immediately force: state IDLE, count/pointers 0, all outputs 0, oDecodeReady 1 after release.
- REQ-034 Reset mid-operation SHALL discard the queue and in-flight instruction with no write or jump afterwards.

Verification
- REQ-035 Push ADD dest=0x0010, ALU ready after 3 cycles, result 0x1/0x2/0x3 -> one-cycle oRAMWriteEnable, addr 0x0010, data {1,2,3}.
- REQ-036 Push 5 instructions back-to-back, ALU stalled (DEPTH=4) -> 4 accepted, oDecodeReady low, oQueueCount=4; 5th accepted after first issue.
- REQ-037 3 queued, first returns iBranchTaken with dest 0x0040 -> oJumpFlag pulse, oJumpIp=0x0040, oQueueCount=0, no writes.
- REQ-038 NOP, then iBranchNotTaken -> no oRAMWriteEnable; next head issues from IDLE.
- REQ-039 ALU never ready, TIMEOUT=8 -> oTimeout set after 8 wait cycles, no write, next instruction issues.
- REQ-040 Reset asserted during WAIT_ALU with 2 queued -> all outputs 0 immediately; after release, ALU ready produces no write.
